vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter: H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter: H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter: H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 Parameter: H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter: V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter: V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter: V_SYNC, default 2, vsync pulse width in lines.
REQ-008 Parameter: V_BP, default 33, vertical back porch in lines.
REQ-009 Parameter: CLK_DIV, default 1, clk cycles per pixel (range 1..4).
REQ-010 Port: clk, input, 1, single system clock; all logic is on its rising edge.
REQ-011 Port: reset, input, 1, synchronous active-high reset.
REQ-012 Port: color_in, input, 6, pixel colour {R[1:0],G[1:0],B[1:0]} for the current colPos/rowPos, combinational from downstream.
REQ-013 Port: colPos, output, 10, current horizontal count (0..H_TOTAL-1).
REQ-014 Port: rowPos, output, 10, current vertical count (0..V_TOTAL-1).
REQ-015 Port: rgb, output, 6, registered colour to the DAC.
REQ-016 Port: hsync, output, 1, active-low horizontal sync, aligned with rgb.
REQ-017 Port: vsync, output, 1, active-low vertical sync, aligned with rgb.
REQ-018 Port: visible, output, 1, high when rgb carries an active-area pixel.
REQ-019 Port: frame_tick, output, 1, one-clk pulse at the start of each frame.

Function
REQ-020 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
REQ-021 Divider counter div counts 0..CLK_DIV-1 and wraps. pix_en is high in each cycle where div == CLK_DIV-1. With CLK_DIV=1, pix_en is always high.
REQ-022 hcount increments on pix_en. When hcount == H_TOTAL-1 it wraps to 0 and vcount increments.
REQ-023 When vcount == V_TOTAL-1 and hcount == H_TOTAL-1, both counters wrap to 0 on the same pix_en.
REQ-024 colPos = hcount and rowPos = vcount, driven directly from the counter registers. Both hold stable between pix_en cycles.
REQ-025 Active area: hcount < H_ACTIVE and vcount < V_ACTIVE.
REQ-026 Sync windows:
  - hsync low when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - vsync low when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (default 490..491).
REQ-027 Output stage updates only on pix_en:
  - rgb <= color_in when the active-area condition holds, otherwise rgb <= 0.
  - visible, hsync and vsync register the values decoded from the same hcount/vcount.
  - Result: rgb and syncs lag colPos/rowPos by exactly one pixel and are mutually aligned.
REQ-028 color_in is sampled only in pix_en cycles. In blanking, color_in is ignored and rgb is forced to 0.
REQ-029 frame_tick is high for exactly one clk cycle: the cycle after the pix_en in which both counters wrap to (0,0).
REQ-030 All counters are wide enough for the total with no overflow. A counter never exceeds TOTAL-1.

Reset
REQ-031 While reset is high on a clk edge, the following take these values:
  - div, hcount, vcount, rgb: 0
  - visible, frame_tick: 0
  - hsync, vsync: 1
REQ-032 Reset overrides pix_en and has the same effect when asserted mid-frame.
REQ-033 On the first pix_en after reset deasserts, hcount advances to 1. No frame_tick is generated for the reset-forced (0,0).

Verification
REQ-034 Defaults, run 2 frames. Required:
  - hsync period 800 clk with low width 96.
  - vsync period 420000 clk with low width 1600 clk.
  - frame_tick period 420000 clk.
REQ-035 color_in tied to 6'b110000. Required:
  - rgb = 110000 for exactly 640 consecutive pixels per line, on lines 0..479.
  - rgb = 0 on all other pixels, with visible matching.
REQ-036 Drive colPos/rowPos at (10,20). Required: rgb shows the colour of pixel (10,20) exactly one pixel later, in the same cycle that visible is high.
REQ-037 Assert reset at hcount=400, vcount=300 for 3 cycles. Required:
  - During reset: colPos=rowPos=0, hsync=vsync=1, rgb=0.
  - After release: counting resumes from 0 with no frame_tick until the next full wrap.
REQ-038 CLK_DIV=2. Required:
  - colPos holds each value for 2 clk.
  - hsync period 1600 clk.
  - frame_tick period 840000 clk and stays exactly 1 clk wide.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters and a registered
// output stage so rgb, syncs and visible all lag colPos/rowPos by one pixel.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] color_in,
  output logic [9:0] colPos,
  output logic [9:0] rowPos,
  output logic [5:0] rgb,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [DIV_W-1:0] div_q, div_d;
  logic [HW-1:0]    hcount_q, hcount_d;
  logic [VW-1:0]    vcount_q, vcount_d;
  logic [5:0]       rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             visible_q, visible_d;
  logic             frameTick_q, frameTick_d;

  logic pixEn;
  logic hEnd;
  logic vEnd;
  logic activeArea;
  logic hSyncWin;
  logic vSyncWin;

  assign pixEn = (div_q == DIV_W'(CLK_DIV - 1));
  assign hEnd  = (hcount_q == HW'(H_TOTAL - 1));
  assign vEnd  = (vcount_q == VW'(V_TOTAL - 1));

  // Compare in int so sync-window bounds equal to TOTAL cannot alias in a narrow counter.
  assign activeArea = (int'(hcount_q) < H_ACTIVE) && (int'(vcount_q) < V_ACTIVE);
  assign hSyncWin   = (int'(hcount_q) >= H_SYNC_START) && (int'(hcount_q) < H_SYNC_END);
  assign vSyncWin   = (int'(vcount_q) >= V_SYNC_START) && (int'(vcount_q) < V_SYNC_END);

  always_comb begin
    div_d    = pixEn ? '0 : div_q + 1'b1;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pixEn) begin
      if (hEnd) begin
        hcount_d = '0;
        vcount_d = vEnd ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end
  end

  always_comb begin
    rgb_d       = activeArea ? color_in : 6'd0;
    visible_d   = activeArea;
    hsync_d     = ~hSyncWin;
    vsync_d     = ~vSyncWin;
    frameTick_d = pixEn && hEnd && vEnd;
  end

  // frame_tick lands in the cycle after the wrapping pix_en, never on a reset-forced (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= '0;
      hcount_q    <= '0;
      vcount_q    <= '0;
      rgb_q       <= '0;
      visible_q   <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      frameTick_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      frameTick_q <= frameTick_d;
      if (pixEn) begin
        rgb_q     <= rgb_d;
        visible_q <= visible_d;
        hsync_q   <= hsync_d;
        vsync_q   <= vsync_d;
      end
    end
  end

  assign colPos     = 10'(hcount_q);
  assign rowPos     = 10'(vcount_q);
  assign rgb        = rgb_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign visible    = visible_q;
  assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small raster at CLK_DIV=1 and CLK_DIV=2, checked
// every clock against a reference model through an expected-value queue.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
    logic       vis;
    logic       tick;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       colorMode;
  logic [9:0] colPos1, rowPos1, colPos2, rowPos2;
  logic [5:0] rgb1, rgb2, color1, color2;
  logic       hs1, vs1, vis1, ft1, hs2, vs2, vis2, ft2;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  function automatic logic [5:0] colorOf(input logic mode, input logic [9:0] h, input logic [9:0] v);
    if (!mode) return 6'b110000;
    return {h[1:0], v[1:0], h[2] ^ v[2], 1'b1};
  endfunction

  assign color1 = colorOf(colorMode, colPos1, rowPos1);
  assign color2 = colorOf(colorMode, colPos2, rowPos2);

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .color_in(color1), .colPos(colPos1), .rowPos(rowPos1),
    .rgb(rgb1), .hsync(hs1), .vsync(vs1), .visible(vis1), .frame_tick(ft1));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .color_in(color2), .colPos(colPos2), .rowPos(rowPos2),
    .rgb(rgb2), .hsync(hs2), .vsync(vs2), .visible(vis2), .frame_tick(ft2));

  exp_t q1[$];
  exp_t q2[$];

  int         mDiv[2], mH[2], mV[2];
  logic [5:0] mRgb[2];
  logic       mHs[2], mVs[2], mVis[2], mTick[2];

  int   lastTick[2]   = '{-1, -1};
  int   lastHsFall[2] = '{-1, -1};
  logic prevFt[2]     = '{1'b0, 1'b0};
  logic prevHs[2]     = '{1'b1, 1'b1};
  int   tickCount[2]  = '{0, 0};
  int   firstTick[2]  = '{-1, -1};

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference raster model, advanced once per clock with the inputs seen before the edge.
  task automatic modelStep(input int k, input int divN, output exp_t e);
    bit pe;
    bit act;
    if (reset) begin
      mDiv[k] = 0; mH[k] = 0; mV[k] = 0;
      mRgb[k] = 6'd0; mVis[k] = 1'b0; mTick[k] = 1'b0;
      mHs[k] = 1'b1; mVs[k] = 1'b1;
    end else begin
      pe = (mDiv[k] == divN - 1);
      mDiv[k] = pe ? 0 : mDiv[k] + 1;
      mTick[k] = pe && (mH[k] == HT - 1) && (mV[k] == VT - 1);
      if (pe) begin
        act = (mH[k] < HA) && (mV[k] < VA);
        mRgb[k] = act ? colorOf(colorMode, 10'(mH[k]), 10'(mV[k])) : 6'd0;
        mVis[k] = act;
        mHs[k] = !((mH[k] >= HA + HF) && (mH[k] < HA + HF + HS));
        mVs[k] = !((mV[k] >= VA + VF) && (mV[k] < VA + VF + VS));
        if (mH[k] == HT - 1) begin
          mH[k] = 0;
          mV[k] = (mV[k] == VT - 1) ? 0 : mV[k] + 1;
        end else begin
          mH[k] = mH[k] + 1;
        end
      end
    end
    e.col = 10'(mH[k]); e.row = 10'(mV[k]); e.rgb = mRgb[k];
    e.hs = mHs[k]; e.vs = mVs[k]; e.vis = mVis[k]; e.tick = mTick[k];
  endtask

  task automatic compareOut(input string nm, input exp_t a, input logic [9:0] col, input logic [9:0] row,
                            input logic [5:0] rgb, input logic hs, input logic vs, input logic vis,
                            input logic ft);
    checkOutput({nm, ".colPos"}, 16'(col), 16'(a.col));
    checkOutput({nm, ".rowPos"}, 16'(row), 16'(a.row));
    checkOutput({nm, ".rgb"}, 16'(rgb), 16'(a.rgb));
    checkOutput({nm, ".hsync"}, 16'(hs), 16'(a.hs));
    checkOutput({nm, ".vsync"}, 16'(vs), 16'(a.vs));
    checkOutput({nm, ".visible"}, 16'(vis), 16'(a.vis));
    checkOutput({nm, ".frame_tick"}, 16'(ft), 16'(a.tick));
  endtask

  // Independent period/width measurements on the sync and tick outputs.
  task automatic measure(input int k, input string nm, input int divN, input logic rstNow,
                         input logic ft, input logic hs);
    if (rstNow) begin
      lastTick[k] = -1; lastHsFall[k] = -1;
    end else begin
      if (prevFt[k]) checkOutput({nm, ".tickWidth"}, 16'(ft), 16'd0);
      if (ft) begin
        if (lastTick[k] >= 0) checkOutput({nm, ".tickPeriod"}, 16'(cycle - lastTick[k]), 16'(divN * HT * VT));
        lastTick[k] = cycle;
        tickCount[k]++;
        if (firstTick[k] < 0) firstTick[k] = cycle;
      end
      if (!hs && prevHs[k]) begin
        if (lastHsFall[k] >= 0) checkOutput({nm, ".hsPeriod"}, 16'(cycle - lastHsFall[k]), 16'(divN * HT));
        lastHsFall[k] = cycle;
      end
      if (hs && !prevHs[k] && lastHsFall[k] >= 0)
        checkOutput({nm, ".hsLowWidth"}, 16'(cycle - lastHsFall[k]), 16'(divN * HS));
    end
    prevFt[k] = ft;
    prevHs[k] = hs;
  endtask

  task automatic applyStimulus();
    exp_t e;
    exp_t a;
    logic rstNow;
    @(negedge clk);
    rstNow = reset;
    modelStep(0, 1, e); q1.push_back(e);
    modelStep(1, 2, e); q2.push_back(e);
    @(posedge clk);
    #1;
    cycle++;
    a = q1.pop_front();
    compareOut("dut1", a, colPos1, rowPos1, rgb1, hs1, vs1, vis1, ft1);
    a = q2.pop_front();
    compareOut("dut2", a, colPos2, rowPos2, rgb2, hs2, vs2, vis2, ft2);
    measure(0, "dut1", 1, rstNow, ft1, hs1);
    measure(1, "dut2", 2, rstNow, ft2, hs2);
  endtask

  initial begin
    int   redCount;
    int   visCount;
    int   relCycle;
    bit   found;
    logic [5:0] expColor;

    reset = 1'b1;
    colorMode = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("reset.hsync", 16'(hs1), 16'd1);
    checkOutput("reset.vsync", 16'(vs2), 16'd1);
    checkOutput("reset.colPos", 16'(colPos1), 16'd0);

    $display("[TB] constant colour, four CLK_DIV=1 frames");
    reset = 1'b0;
    redCount = 0;
    visCount = 0;
    relCycle = cycle;
    for (int i = 0; i < 4 * HT * VT; i++) begin
      applyStimulus();
      if (rgb1 == 6'b110000) redCount++;
      if (vis1) visCount++;
    end
    checkOutput("dut1.redPixels", 16'(redCount), 16'(4 * HA * VA));
    checkOutput("dut1.visiblePixels", 16'(visCount), 16'(4 * HA * VA));
    checkOutput("dut1.firstTick", 16'(firstTick[0] - relCycle), 16'(HT * VT));
    checkOutput("dut2.firstTick", 16'(firstTick[1] - relCycle), 16'(2 * HT * VT));

    $display("[TB] pixel (3,2) latency");
    colorMode = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2 * HT * VT && !found; i++) begin
      applyStimulus();
      if (colPos1 == 10'd3 && rowPos1 == 10'd2) found = 1'b1;
    end
    checkOutput("find(3,2)", 16'(found), 16'd1);
    expColor = colorOf(1'b1, 10'd3, 10'd2);
    applyStimulus();
    checkOutput("pix(3,2).rgb", 16'(rgb1), 16'(expColor));
    checkOutput("pix(3,2).visible", 16'(vis1), 16'd1);

    $display("[TB] mid-frame reset");
    found = 1'b0;
    for (int i = 0; i < 2 * HT * VT && !found; i++) begin
      applyStimulus();
      if (colPos1 == 10'd5 && rowPos1 == 10'd4) found = 1'b1;
    end
    checkOutput("find(5,4)", 16'(found), 16'd1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("midReset.colPos", 16'(colPos1), 16'd0);
      checkOutput("midReset.rowPos", 16'(rowPos1), 16'd0);
      checkOutput("midReset.hsync", 16'(hs1), 16'd1);
      checkOutput("midReset.vsync", 16'(vs1), 16'd1);
      checkOutput("midReset.rgb", 16'(rgb1), 16'd0);
    end
    reset = 1'b0;
    tickCount = '{0, 0};
    firstTick = '{-1, -1};
    relCycle = cycle;
    for (int i = 0; i < 400; i++) applyStimulus();
    checkOutput("dut1.ticksAfterReset", 16'(tickCount[0]), 16'd2);
    checkOutput("dut1.firstTickAfterReset", 16'(firstTick[0] - relCycle), 16'(HT * VT));
    checkOutput("dut2.ticksAfterReset", 16'(tickCount[1]), 16'd1);
    checkOutput("dut2.firstTickAfterReset", 16'(firstTick[1] - relCycle), 16'(2 * HT * VT));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
